alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
// PURPOSE
//  Sequences one shared alu32 instance between two requesters: port 0 (main
//  datapath) and port 1 (address/branch unit). It arbitrates round-robin,
//  registers the operands, drives the ALU for one cycle and captures the result.
//  It also holds the architectural status register fed from the ALU stat output.
//  Sits between the requesters and the combinational alu32; alu32 stays unmodified.
// PARAMETERS
//  WIDTH  32  operand/result width; must equal alu32 width
//  OPW    3   ALU control-line (gin) width
// PORTS
//  clk       in   1      system clock, rising edge
//  reset     in   1      asynchronous, active-high reset
//  req0      in   1      port 0 request; held high until done0
//  a0,b0     in   WIDTH  port 0 operands; sampled on grant
//  op0       in   OPW    port 0 ALU control line; sampled on grant
//  req1      in   1      port 1 request; held high until done1
//  a1,b1     in   WIDTH  port 1 operands; sampled on grant
//  op1       in   OPW    port 1 ALU control line; sampled on grant
//  gnt0/1    out  1      one-cycle pulse: request accepted, operands latched
//  done0/1   out  1      one-cycle pulse: result valid for that port
//  err       out  1      qualifies done: the op was illegal (3'b101)
//  result    out  WIDTH  registered result; held until next capture
//  stat_q    out  2      status register: [1]=zero, [0]=1 when result[31]==0
//  alu_a     out  WIDTH  to alu32 a
//  alu_b     out  WIDTH  to alu32 b
//  alu_gin   out  OPW    to alu32 gin
//  alu_sum   in   WIDTH  from alu32 sum
//  alu_stat  in   2      from alu32 stat
// BEHAVIOUR
//  - Reset values (async, immediate): state=IDLE, rr_ptr=0 (port 0 preferred);
//    all gnt/done/err=0; result=0; stat_q=2'b00; alu_a/alu_b=0; alu_gin=3'b010.
//  - FSM: IDLE -> EXEC -> DONE -> IDLE; 3 cycles per op; at most 1 op in flight.
//  - IDLE:
//    - If no req is high, stay in IDLE.
//    - If only one req is high, grant that port.
//    - If both are high, grant the port rr_ptr points at.
//    - On grant: pulse gnt, latch a/b/op into the operand registers and the
//      port id into own_q, go to EXEC.
//  - EXEC: alu_a/alu_b/alu_gin are driven from registers and stay stable the
//    whole cycle. At the clock edge:
//    - result <= alu_sum and stat_q <= alu_stat;
//    - rr_ptr <= ~own_q;
//    - go to DONE.
//  - DONE: pulse done for own_q. Return to IDLE; a new grant is possible on the
//    next cycle, so back-to-back throughput is one op per 3 cycles.
//  - Illegal op 3'b101:
//    - latched normally, but EXEC drives alu_gin=3'b010;
//    - result <= 0; stat_q is unchanged; err=1 with done in DONE;
//    - rr_ptr still advances.
//  - stat_q updates only on a legal EXEC capture; it holds across idle cycles.
//  - A req dropped after its gnt is ignored; the op completes and done still
//    pulses. A req dropped before its gnt is never granted.
//  - A req already high in the DONE cycle is considered in the following IDLE.
//    A requester whose req stays high is never starved: the other port waits at
//    most 1 op.
//  - Reset asserted in EXEC or DONE aborts the op: no done pulse, all outputs
//    return to their reset values. A requester must re-request after reset.
//  - No arithmetic is done here; widths pass through unchanged.
// TESTING
//  1. req0, a0=5, b0=3, op0=010 -> gnt0 @t, done0 @t+2, result=8, stat_q=01, err=0.
//  2. req1, a1=7, b1=7, op1=110 -> result=0, stat_q=11.
//     Then port 0 runs 1-2 (op 110): result=32'hFFFFFFFF, stat_q=00.
//  3. req0 and req1 both high after reset -> port 0 first, port 1 next.
//     With both held for 4 ops: grants 0,1,0,1; gnt spacing exactly 3 cycles.
//  4. req0, op0=101 -> done0 and err=1, result=0, stat_q keeps its prior value;
//     the next legal op clears err.
//  5. reset pulsed during EXEC -> no done pulse, result=0, stat_q=00, rr_ptr=0.
//     After reset, with req1 held: gnt1 follows 1 cycle after reset deasserts.
//  6. req0, a0=1, b0=4, op0=100 (SLLV) -> result=16.
//     Then op0=111 with a0=2, b0=9 -> result=1, stat_q=01.

Source files
------------

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_ctrl
// Description : Time-shares one combinational alu32 between two requesters.
//               Port 0 is the main datapath, port 1 the address/branch unit.
//               Requests are arbitrated round-robin. The winning operands are
//               registered straight into the ALU input registers. The ALU sum
//               is captured one cycle later. Completion is signalled one cycle
//               after that. The block also owns the architectural status
//               register, which is loaded from the ALU stat output.
//
//               Op sequence (3 cycles, one op in flight at most):
//                 IDLE --grant--> EXEC --capture--> DONE --> IDLE
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-high reset
//   req0/req1           requests; held high by the requester until its done
//   a0,b0,op0           port 0 operands / ALU control line, sampled on grant
//   a1,b1,op1           port 1 operands / ALU control line, sampled on grant
//   gnt0/gnt1           one-cycle pulse: request accepted, operands latched
//   done0/done1         one-cycle pulse: result valid for that port
//   err                 qualifies done: the op was the illegal code 3'b101
//   result              registered ALU result, held until the next capture
//   stat_q              status register: [1]=zero, [0]=result non-negative
//   alu_a/alu_b/alu_gin registered drive to alu32
//   alu_sum/alu_stat    returned from alu32
//
// Revision    : 1.0  initial release
// ============================================================================
module alu_share_ctrl #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [OPW-1:0]   op0,

    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [OPW-1:0]   op1,

    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       stat_q,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_gin,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic [1:0]       alu_stat
);

    // ALU control codes. ADD doubles as the safe idle/illegal-op drive so the
    // ALU never sees an undefined control line.
    localparam logic [OPW-1:0] c_op_add     = OPW'(3'b010);
    localparam logic [OPW-1:0] c_op_illegal = OPW'(3'b101);

    typedef enum logic [1:0] {
        c_st_idle = 2'd0,
        c_st_exec = 2'd1,
        c_st_done = 2'd2
    } state_t;

    state_t r_state;
    logic   r_rr_ptr;   // port preferred when both request (0 = port 0)
    logic   r_own_q;    // port that owns the op in flight
    logic   r_illegal;  // op in flight carried the illegal control code

    // ------------------------------------------------------------------------
    // Grant selection. Port 1 wins when it is the only requester, or when
    // both request and the round-robin pointer favours it.
    // ------------------------------------------------------------------------
    logic             w_any_req;
    logic             w_pick1;
    logic [WIDTH-1:0] w_a_sel;
    logic [WIDTH-1:0] w_b_sel;
    logic [OPW-1:0]   w_op_sel;
    logic             w_op_illegal;

    always_comb begin
        w_any_req    = req0 | req1;
        w_pick1      = req1 & (~req0 | r_rr_ptr);
        w_a_sel      = w_pick1 ? a1  : a0;
        w_b_sel      = w_pick1 ? b1  : b0;
        w_op_sel     = w_pick1 ? op1 : op0;
        w_op_illegal = (w_op_sel == c_op_illegal);
    end

    // ------------------------------------------------------------------------
    // Sequencer. All outputs are registered. gnt/done/err default low every
    // cycle so each assertion is a single-cycle pulse.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_rr_ptr  <= 1'b0;
            r_own_q   <= 1'b0;
            r_illegal <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
            stat_q    <= 2'b00;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_gin   <= c_op_add;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            err   <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (w_any_req) begin
                        gnt0      <= ~w_pick1;
                        gnt1      <= w_pick1;
                        r_own_q   <= w_pick1;
                        // The ALU input registers are the operand registers.
                        // They stay stable for the whole EXEC cycle.
                        alu_a     <= w_a_sel;
                        alu_b     <= w_b_sel;
                        alu_gin   <= w_op_illegal ? c_op_add : w_op_sel;
                        r_illegal <= w_op_illegal;
                        r_state   <= c_st_exec;
                    end
                end

                c_st_exec: begin
                    // An illegal op returns zero and leaves the status untouched.
                    // The ALU is still run (as ADD), but its output is discarded.
                    if (r_illegal) begin
                        result <= '0;
                    end else begin
                        result <= alu_sum;
                        stat_q <= alu_stat;
                    end
                    r_rr_ptr <= ~r_own_q;
                    r_state  <= c_st_done;
                end

                c_st_done: begin
                    done0   <= ~r_own_q;
                    done1   <= r_own_q;
                    err     <= r_illegal;
                    r_state <= c_st_idle;
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_ctrl
// Description : Directed self-checking bench for alu_share_ctrl. A small
//               behavioural alu32 closes the loop on the ALU ports.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_share_ctrl;

    localparam int WIDTH = 32;
    localparam int OPW   = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0, req1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [OPW-1:0]   op0, op1;
    logic             gnt0, gnt1, done0, done1, err;
    logic [WIDTH-1:0] result;
    logic [1:0]       stat_q;
    logic [WIDTH-1:0] alu_a, alu_b, alu_sum;
    logic [OPW-1:0]   alu_gin;
    logic [1:0]       alu_stat;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .a0       (a0),
        .b0       (b0),
        .op0      (op0),
        .req1     (req1),
        .a1       (a1),
        .b1       (b1),
        .op1      (op1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .err      (err),
        .result   (result),
        .stat_q   (stat_q),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_gin  (alu_gin),
        .alu_sum  (alu_sum),
        .alu_stat (alu_stat)
    );

    // Behavioural alu32: AND, OR, ADD, SLLV, SUB, SLT.
    always_comb begin
        case (alu_gin)
            3'b000:  alu_sum = alu_a & alu_b;
            3'b001:  alu_sum = alu_a | alu_b;
            3'b010:  alu_sum = alu_a + alu_b;
            3'b100:  alu_sum = alu_a << alu_b[4:0];
            3'b110:  alu_sum = alu_a - alu_b;
            3'b111:  alu_sum = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_sum = 32'hDEAD_BEEF;
        endcase
        alu_stat = {(alu_sum == 32'd0), ~alu_sum[31]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One op on a single port with no competing request.
    // Timeline: gnt at t, result at t+1, done/err at t+2, quiet at t+3.
    task automatic op_single(input bit port, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, input logic [31:0] exp_res,
                             input logic [1:0] exp_stat, input logic exp_err);
        logic [2:0] exp_gin;
        exp_gin = (op == 3'b101) ? 3'b010 : op;
        if (port) begin
            req1 = 1'b1; a1 = a; b1 = b; op1 = op;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b; op0 = op;
        end
        step();
        chk("gnt",       32'(port ? gnt1 : gnt0), 32'd1);
        chk("other_gnt", 32'(port ? gnt0 : gnt1), 32'd0);
        chk("alu_a",     alu_a, a);
        chk("alu_b",     alu_b, b);
        chk("alu_gin",   32'(alu_gin), 32'(exp_gin));
        // Drop the request and scramble inputs: the latched op must still complete.
        req0 = 1'b0; req1 = 1'b0;
        a0 = '1; b0 = '1; a1 = '1; b1 = '1;
        step();
        chk("done_early", 32'(port ? done1 : done0), 32'd0);
        chk("result_t1",  result, exp_res);
        step();
        chk("done",       32'(port ? done1 : done0), 32'd1);
        chk("done_other", 32'(port ? done0 : done1), 32'd0);
        chk("err",        32'(err), 32'(exp_err));
        chk("result",     result, exp_res);
        chk("stat_q",     32'(stat_q), 32'(exp_stat));
        step();
        chk("done_pulse", 32'(port ? done1 : done0), 32'd0);
        chk("err_pulse",  32'(err), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; op0 = '0;
        a1 = '0; b1 = '0; op1 = '0;

        // Reset values
        step();
        chk("rst_gnt0",   32'(gnt0), 32'd0);
        chk("rst_gnt1",   32'(gnt1), 32'd0);
        chk("rst_done0",  32'(done0), 32'd0);
        chk("rst_done1",  32'(done1), 32'd0);
        chk("rst_err",    32'(err), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_stat",   32'(stat_q), 32'd0);
        chk("rst_alu_a",  alu_a, 32'd0);
        chk("rst_alu_b",  alu_b, 32'd0);
        chk("rst_gin",    32'(alu_gin), 32'd2);
        reset = 1'b0;
        step();

        // Add, subtract to zero, subtract to negative
        op_single(1'b0, 32'd5, 32'd3, 3'b010, 32'd8, 2'b01, 1'b0);
        op_single(1'b1, 32'd7, 32'd7, 3'b110, 32'd0, 2'b11, 1'b0);
        op_single(1'b0, 32'd1, 32'd2, 3'b110, 32'hFFFF_FFFF, 2'b00, 1'b0);

        // Illegal op: result forced to 0, status held, err with done
        op_single(1'b0, 32'd5, 32'd3, 3'b101, 32'd0, 2'b00, 1'b1);
        step(); step(); step();
        chk("stat_hold_idle", 32'(stat_q), 32'd0);

        // SLLV then SLT; the first legal op after the illegal one clears err
        op_single(1'b0, 32'd1, 32'd4, 3'b100, 32'd16, 2'b01, 1'b0);
        op_single(1'b0, 32'd2, 32'd9, 3'b111, 32'd1, 2'b01, 1'b0);

        // Abort during EXEC while rr_ptr favours port 1
        req0 = 1'b1; a0 = 32'd9; b0 = 32'd9; op0 = 3'b010;
        step();
        chk("abort_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("abort_result", result, 32'd0);
        chk("abort_stat",   32'(stat_q), 32'd0);
        chk("abort_alu_a",  alu_a, 32'd0);
        chk("abort_gin",    32'(alu_gin), 32'd2);
        chk("abort_gnt0_0", 32'(gnt0), 32'd0);
        step();
        chk("abort_done0_a", 32'(done0), 32'd0);
        step();
        chk("abort_done0_b", 32'(done0), 32'd0);

        // Both requesting right after reset: port 0 first, then alternate
        // every 3 cycles.
        reset = 1'b0;
        req0 = 1'b1; a0 = 32'd10;  b0 = 32'd20; op0 = 3'b010;
        req1 = 1'b1; a1 = 32'd100; b1 = 32'd1;  op1 = 3'b110;
        for (int k = 1; k <= 13; k++) begin
            step();
            chk($sformatf("rr_gnt0_k%0d", k),  32'(gnt0),  32'(k == 1 || k == 7));
            chk($sformatf("rr_gnt1_k%0d", k),  32'(gnt1),  32'(k == 4 || k == 10));
            chk($sformatf("rr_done0_k%0d", k), 32'(done0), 32'(k == 3 || k == 9));
            chk($sformatf("rr_done1_k%0d", k), 32'(done1), 32'(k == 6 || k == 12));
            if (k == 3 || k == 9)
                chk($sformatf("rr_res0_k%0d", k), result, 32'd30);
            if (k == 6 || k == 12)
                chk($sformatf("rr_res1_k%0d", k), result, 32'd99);
            if (k == 10) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end

        // Abort during a port-1 EXEC with req1 kept high: regrant one cycle
        // after reset releases.
        req1 = 1'b1; a1 = 32'd3; b1 = 32'd4; op1 = 3'b010;
        step();
        chk("abort2_gnt1", 32'(gnt1), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort2_result", result, 32'd0);
        step();
        chk("abort2_done1", 32'(done1), 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_gnt1", 32'(gnt1), 32'd1);
        chk("post_rst_gnt0", 32'(gnt0), 32'd0);
        req1 = 1'b0;
        step();
        step();
        chk("post_rst_done1",  32'(done1), 32'd1);
        chk("post_rst_result", result, 32'd7);
        chk("post_rst_stat",   32'(stat_q), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
